fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO, the next generation of the team's fixed 8-bit FIFO. Width, depth and watermark thresholds are set by parameters. It adds a fill-level count, almost-full/almost-empty watermarks, sticky overflow/underflow error flags and a synchronous flush. It sits between a streaming producer and consumer in the same clock domain and is used wherever the old FIFO was.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥4.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; range 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- Derived `CW` = $clog2(DEPTH)+1, the count width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous empty request.
- `data_in` in WIDTH: write data.
- `write_en` in 1: write request.
- `read_en` in 1: read request.
- `clear_err` in 1: clears the sticky error flags.
- `data_out` out WIDTH: registered read data.
- `read_valid` out 1: `data_out` holds newly read data this cycle.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `almost_empty` out 1: count ≤ AE_THRESH.
- `almost_full` out 1: count ≥ AF_THRESH.
- `count` out CW: current number of stored entries.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Storage: array of DEPTH×WIDTH words. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `count` is a separate CW-bit register.
- Write accepted iff `write_en && !full`, using the registered `full` at the start of the cycle. An accepted write stores `data_in` at the write pointer and increments the pointer.
- Read accepted iff `read_en && !empty`. An accepted read loads the word at the read pointer into `data_out` and increments the pointer.
- Count update:
  - write only accepted: count +1.
  - read only accepted: count −1.
  - both accepted: count unchanged.
  - neither: unchanged.
- Full with simultaneous `write_en` and `read_en`: the read is accepted, the write is rejected and `overflow` sets. Count goes DEPTH → DEPTH-1.
- Empty with simultaneous `write_en` and `read_en`: the write is accepted, the read is rejected and `underflow` sets. Count goes 0 → 1. There is no fall-through.
- `overflow` sets on `write_en && full`. `underflow` sets on `read_en && empty`. Both hold until `clear_err` or reset.
- If `clear_err` and a new error event occur in the same cycle, the flag stays set (set wins).
- `flush`:
  - Next cycle: pointers = 0, count = 0, `read_valid` = 0.
  - Overrides `write_en` and `read_en` in the same cycle; no write or read is accepted.
  - `data_out`, the memory contents and the error flags are unchanged.
  - Flush does not set error flags, even if requests were ignored.
- Flags `empty`, `full`, `almost_empty` and `almost_full` are registered, decoded from the next-state count, so they are valid in the same cycle as `count`.

## Timing
- Reset (`rst_n` low, asynchronous assert, synchronous deassert edge):
  - `data_out` = 0, `read_valid` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `almost_empty` = 1 (AE_THRESH ≥ 0).
  - `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
  - Pointers = 0. Memory contents are not reset.
- Reset mid-operation discards all stored data. The first cycle after release behaves as empty.
- Read latency: a read accepted at edge N drives `data_out` and `read_valid` = 1 after edge N. `read_valid` is a one-cycle pulse per accepted read; back-to-back reads give continuous `read_valid`.
- `data_out` holds its last value when no read is accepted.
- Write-to-read: data written at edge N is readable from edge N+1 (`empty` drops after edge N).
- `count` and all flags update one edge after the accepting request.

## Test plan
Parameters for all scenarios: WIDTH=8, DEPTH=16, AF=14, AE=2.
- **Reset values:** hold `rst_n`=0 for 5 cycles, then release → `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `data_out`=0x00, error flags 0.
- **Fill and overflow:** write 0..15, then one more write of 0xAA → `almost_full` rises at count 14, `full`=1 at count 16, `overflow`=1, `count` stays 16. Read 16 → `data_out` sequence 0..15, each with `read_valid`, and 0xAA never appears.
- **Underflow on empty plus simultaneous access:** with the FIFO empty, assert `read_en`+`write_en` with 0x55 → `underflow`=1, `count`=1, no `read_valid`. Next cycle read → `data_out`=0x55. Then pulse `clear_err` → `underflow`=0.
- **Full with simultaneous access:** with the FIFO full, assert `read_en`+`write_en` → `count`=15, `overflow`=1, read data = oldest entry.
- **Wrap-around streaming:** write 5, read 3, then 40 cycles of concurrent write (incrementing data) and read → output strictly in-order, `count` constant at 2, no error flags.
- **Flush and async reset mid-stream:**
  - Fill 10 entries, assert `flush` with `write_en`=1 → next cycle `count`=0, `empty`=1, `data_out` unchanged, nothing written.
  - Refill 6 entries, assert `rst_n`=0 mid-cycle → outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fifo_param                                                      |
// | Brief    : Parametrised synchronous FIFO with fill count, watermarks,      |
// |            sticky overflow/underflow flags and synchronous flush.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             read_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_next;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses the registered flags; flush suppresses both ports.
  assign wr_acc = write_en && !full  && !flush;
  assign rd_acc = read_en  && !empty && !flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      read_valid   <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      if (rd_acc) data_out <= mem[rd_ptr];
      read_valid   <= rd_acc;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == C_DEPTH);
      almost_empty <= (count_next <= C_AE);
      almost_full  <= (count_next >= C_AF);
      // A new error event in the same cycle as clear_err keeps the flag set.
      overflow  <= (write_en && full  && !flush) || (overflow  && !clear_err);
      underflow <= (read_en  && empty && !flush) || (underflow && !clear_err);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fifo_param                                                   |
// | Brief    : Scoreboard bench for fifo_param against a queue-based model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             write_en = 1'b0;
  logic             read_en = 1'b0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             read_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .clear_err(clear_err),
    .data_out(data_out), .read_valid(read_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 1'b0;

  // Reference model: the FIFO contents as a queue plus the visible registers.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit m_rv  = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_update(input bit we, input bit re, input logic [WIDTH-1:0] d,
                              input bit fl, input bit ce);
    bit was_full, was_empty;
    if (!rst_n) return;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_rv = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (re && !was_empty) begin
        m_dout = mq.pop_front();
        m_rv   = 1'b1;
        sb.push_back(m_dout);
      end
      if (we && !was_full) mq.push_back(d);
    end
    m_ovf = (!fl && we && was_full)  || (m_ovf && !ce);
    m_unf = (!fl && re && was_empty) || (m_unf && !ce);
  endtask

  task automatic step(input bit we, input bit re, input logic [WIDTH-1:0] d,
                      input bit fl = 1'b0, input bit ce = 1'b0);
    write_en = we; read_en = re; data_in = d; flush = fl; clear_err = ce;
    @(posedge clk);
    model_update(we, re, d, fl, ce);
    #1;
    write_en = 1'b0; read_en = 1'b0; flush = 1'b0; clear_err = 1'b0;
  endtask

  // Monitor: compares every visible output on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("read_valid", read_valid, m_rv);
      if (read_valid === 1'b1) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL sb_underrun: actual read_valid=1 required no pending read at %0t", $time);
        end else begin
          chk("read_data", data_out, sb.pop_front());
        end
      end
      chk("data_out", data_out, m_dout);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("almost_empty", almost_empty, mq.size() <= AE);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
    end
  end

  logic [WIDTH-1:0] seq;

  initial begin
    // Reset values.
    #1 rst_n = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    step(0, 0, 0);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(i));
    step(1, 0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Empty with simultaneous access, then clear.
    step(1, 1, 8'h55);
    step(0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Full with simultaneous access.
    for (int i = 0; i < DEPTH; i++) step(1, 0, WIDTH'(8'h30 + i));
    step(1, 1, 8'h77);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 0, 0, 0, 1);

    // Wrap-around streaming.
    seq = 8'h80;
    for (int i = 0; i < 5; i++) begin step(1, 0, seq); seq++; end
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    for (int i = 0; i < 40; i++) begin step(1, 1, seq); seq++; end
    step(0, 1, 0);
    step(0, 1, 0);

    // Flush with a concurrent write.
    for (int i = 0; i < 10; i++) step(1, 0, WIDTH'(8'hC0 + i));
    step(0, 1, 0);
    step(1, 0, 8'hEE, 1);
    step(0, 0, 0);

    // Refill then asynchronous reset between edges.
    for (int i = 0; i < 6; i++) step(1, 0, WIDTH'(8'hD0 + i));
    step(0, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    chk("async_read_valid", read_valid, 0);
    chk("async_data_out", data_out, 0);
    chk("async_almost_empty", almost_empty, 1);
    step(1, 1, 8'h11);
    #1 rst_n = 1'b1;
    step(0, 1, 0);
    step(1, 0, 8'h22);
    step(0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
           WIDTH'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0);
    step(0, 0, 0);

    mon_en = 1'b0;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
